// File: rtl/d2_ag_skid_buffer.sv
// Two-entry skid buffer between decode stage 2 and AG; one-cycle latency, no bypass, 1 bundle/cycle.
// Backpressure: LD_D2_OUT comes from registered state only; it drops when full or while a jump/exception is pending.
module d2_ag_skid_buffer #(
    parameter int PAYLOAD_W = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 D2_V_IN,
    input  logic [PAYLOAD_W-1:0] D2_PAYLOAD_IN,
    input  logic                 D2_JMP_STALL_IN,
    input  logic                 D2_EXC_EN_V_IN,
    output logic                 LD_D2_OUT,
    output logic                 AG_V_OUT,
    output logic [PAYLOAD_W-1:0] AG_PAYLOAD_OUT,
    input  logic                 AG_READY_IN,
    input  logic                 JMP_RESOLVED_IN,
    input  logic                 FLUSH_IN,
    output logic [1:0]           OCC_OUT,
    output logic [1:0]           STATE_OUT
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_JMP_WAIT = 2'b01,
        ST_EXC_WAIT = 2'b10
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PAYLOAD_W-1:0] r_slot [2];
    logic                 r_head;
    logic [1:0]           r_count;
    logic [1:0]           w_count_nxt;
    logic                 w_head_nxt;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_tail;

    assign LD_D2_OUT      = ~reset & (r_count != 2'd2) & (r_state == ST_RUN);
    assign AG_V_OUT       = (r_count != 2'd0);
    assign AG_PAYLOAD_OUT = r_slot[r_head];
    assign OCC_OUT        = r_count;
    assign STATE_OUT      = r_state;

    assign w_accept = D2_V_IN & LD_D2_OUT;
    assign w_pop    = AG_V_OUT & AG_READY_IN;
    // Tail is head when empty, the other slot when one entry is held; never written when full.
    assign w_tail   = r_head ^ r_count[0];

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_head_nxt  = r_head;
        if (FLUSH_IN) begin
            w_state_nxt = ST_RUN;
            w_count_nxt = 2'd0;
        end else begin
            case ({w_accept, w_pop})
                2'b10: w_count_nxt = r_count + 2'd1;
                2'b01: begin
                    w_count_nxt = r_count - 2'd1;
                    w_head_nxt  = ~r_head;
                end
                2'b11: w_head_nxt = ~r_head;
                default: ;
            endcase

            case (r_state)
                ST_RUN: begin
                    // Exception wins over a jump carried by the same bundle.
                    if (w_accept && D2_EXC_EN_V_IN)
                        w_state_nxt = ST_EXC_WAIT;
                    else if (w_accept && D2_JMP_STALL_IN)
                        w_state_nxt = ST_JMP_WAIT;
                end
                ST_JMP_WAIT: begin
                    if (JMP_RESOLVED_IN)
                        w_state_nxt = ST_RUN;
                end
                ST_EXC_WAIT: ;
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_count <= 2'd0;
            r_head  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot[0] <= '0;
            r_slot[1] <= '0;
        end else if (w_accept && !FLUSH_IN) begin
            r_slot[w_tail] <= D2_PAYLOAD_IN;
        end
    end

endmodule

// File: tb/tb_d2_ag_skid_buffer.sv
// Bench for d2_ag_skid_buffer: directed vector table followed by randomized traffic against a queue model.
module tb_d2_ag_skid_buffer;
    localparam int PW = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          d2_v, d2_jmp, d2_exc, ag_rdy, jmp_res, flush;
    logic [PW-1:0] d2_pay;
    logic          ld_d2, ag_v;
    logic [PW-1:0] ag_pay;
    logic [1:0]    occ, st;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    d2_ag_skid_buffer #(.PAYLOAD_W(PW)) dut (
        .clk             (clk),
        .reset           (reset),
        .D2_V_IN         (d2_v),
        .D2_PAYLOAD_IN   (d2_pay),
        .D2_JMP_STALL_IN (d2_jmp),
        .D2_EXC_EN_V_IN  (d2_exc),
        .LD_D2_OUT       (ld_d2),
        .AG_V_OUT        (ag_v),
        .AG_PAYLOAD_OUT  (ag_pay),
        .AG_READY_IN     (ag_rdy),
        .JMP_RESOLVED_IN (jmp_res),
        .FLUSH_IN        (flush),
        .OCC_OUT         (occ),
        .STATE_OUT       (st)
    );

    typedef struct {
        logic        rst, v, jmp, exc, rdy, res, fl;
        logic [31:0] pay;
        logic        e_ld, e_v;
        logic [31:0] e_pay;
        logic [1:0]  e_occ, e_st;
        logic        chk_pay;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic v, logic [31:0] pay, logic jmp, logic exc,
                                logic rdy, logic res, logic fl, logic e_ld, logic e_v,
                                logic [31:0] e_pay, logic [1:0] e_occ, logic [1:0] e_st,
                                logic chk_pay);
        vec_t t;
        t.rst = rst; t.v = v; t.pay = pay; t.jmp = jmp; t.exc = exc;
        t.rdy = rdy; t.res = res; t.fl = fl;
        t.e_ld = e_ld; t.e_v = e_v; t.e_pay = e_pay; t.e_occ = e_occ; t.e_st = e_st;
        t.chk_pay = chk_pay;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic [PW-1:0] pay,
                         input logic jmp, input logic exc, input logic rdy,
                         input logic res, input logic fl);
        reset = rst; d2_v = v; d2_pay = pay; d2_jmp = jmp; d2_exc = exc;
        ag_rdy = rdy; jmp_res = res; flush = fl;
    endtask

    // Reference model: ordered queue of held bundles plus the decode-blocking mode.
    logic [PW-1:0] mq[$];
    logic [1:0]    ms;

    initial begin
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        //           rst v  pay    j  e  rdy res fl   ld v  epay  occ st   chkpay
        // reset state
        tbl.push_back(mk(1, 0, 32'h0,  0, 0, 0, 0, 0,  0, 0, 32'h0,  0, 0, 1));
        // streaming with AG ready: occupancy stays 1
        tbl.push_back(mk(0, 1, 32'h1,  0, 0, 1, 0, 0,  1, 0, 32'h0,  0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h2,  0, 0, 1, 0, 0,  1, 1, 32'h1,  1, 0, 1));
        tbl.push_back(mk(0, 1, 32'h3,  0, 0, 1, 0, 0,  1, 1, 32'h2,  1, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,  0, 0, 1, 0, 0,  1, 1, 32'h3,  1, 0, 1));
        // AG stalled: two absorbed, third held upstream, then drained in order
        tbl.push_back(mk(0, 1, 32'hA,  0, 0, 0, 0, 0,  1, 0, 32'h0,  0, 0, 0));
        tbl.push_back(mk(0, 1, 32'hB,  0, 0, 0, 0, 0,  1, 1, 32'hA,  1, 0, 1));
        tbl.push_back(mk(0, 1, 32'hC,  0, 0, 0, 0, 0,  0, 1, 32'hA,  2, 0, 1));
        tbl.push_back(mk(0, 1, 32'hC,  0, 0, 1, 0, 0,  0, 1, 32'hA,  2, 0, 1));
        tbl.push_back(mk(0, 1, 32'hC,  0, 0, 1, 0, 0,  1, 1, 32'hB,  1, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,  0, 0, 1, 0, 0,  1, 1, 32'hC,  1, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0,  1, 0, 32'h0,  0, 0, 0));
        // jump: blocks decode while draining, released after resolve pulse
        tbl.push_back(mk(0, 1, 32'h10, 1, 0, 0, 0, 0,  1, 0, 32'h0,  0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h11, 0, 0, 1, 0, 0,  0, 1, 32'h10, 1, 1, 1));
        tbl.push_back(mk(0, 1, 32'h11, 0, 0, 1, 1, 0,  0, 0, 32'h0,  0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h11, 0, 0, 0, 0, 0,  1, 0, 32'h0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,  0, 0, 1, 0, 0,  1, 1, 32'h11, 1, 0, 1));
        // exception with jump flag: resolve ignored, only flush releases
        tbl.push_back(mk(0, 1, 32'h20, 1, 1, 0, 0, 0,  1, 0, 32'h0,  0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h21, 0, 0, 0, 1, 0,  0, 1, 32'h20, 1, 2, 1));
        tbl.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0,  0, 1, 32'h20, 1, 2, 1));
        tbl.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1,  0, 1, 32'h20, 1, 2, 1));
        tbl.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0,  1, 0, 32'h0,  0, 0, 0));
        // full + flush + pop + valid: everything discarded
        tbl.push_back(mk(0, 1, 32'h30, 0, 0, 0, 0, 0,  1, 0, 32'h0,  0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h31, 0, 0, 0, 0, 0,  1, 1, 32'h30, 1, 0, 1));
        tbl.push_back(mk(0, 1, 32'h32, 0, 0, 1, 0, 1,  0, 1, 32'h30, 2, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,  0, 0, 1, 0, 0,  1, 0, 32'h0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,  0, 0, 1, 0, 0,  1, 0, 32'h0,  0, 0, 0));
        // reset while full in JMP_WAIT
        tbl.push_back(mk(0, 1, 32'h40, 0, 0, 0, 0, 0,  1, 0, 32'h0,  0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h41, 1, 0, 0, 0, 0,  1, 1, 32'h40, 1, 0, 1));
        tbl.push_back(mk(1, 1, 32'h42, 0, 0, 1, 0, 0,  0, 1, 32'h40, 2, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0,  1, 0, 32'h0,  0, 0, 1));
        // flush and resolve in the same cycle
        tbl.push_back(mk(0, 1, 32'h50, 1, 0, 0, 0, 0,  1, 0, 32'h0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1, 1,  0, 1, 32'h50, 1, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0,  1, 0, 32'h0,  0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].v, PW'(tbl[i].pay), tbl[i].jmp, tbl[i].exc,
                  tbl[i].rdy, tbl[i].res, tbl[i].fl);
            #1;
            chk("vec_ld",    i, PW'(ld_d2), PW'(tbl[i].e_ld));
            chk("vec_agv",   i, PW'(ag_v),  PW'(tbl[i].e_v));
            chk("vec_occ",   i, PW'(occ),   PW'(tbl[i].e_occ));
            chk("vec_state", i, PW'(st),    PW'(tbl[i].e_st));
            if (tbl[i].chk_pay)
                chk("vec_pay", i, ag_pay, PW'(tbl[i].e_pay));
            @(posedge clk);
            #1;
        end

        // Randomized traffic; starts from a reset cycle so the model begins empty.
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        mq.delete();
        ms = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            logic          r_rst, r_v, r_j, r_e, r_rdy, r_res, r_fl;
            logic          e_ld, acc, pp;
            logic [PW-1:0] r_pay;
            r_rst = ($urandom_range(0, 299) == 0);
            r_v   = ($urandom_range(0, 3) != 0);
            r_j   = ($urandom_range(0, 7) == 0);
            r_e   = ($urandom_range(0, 15) == 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_res = ($urandom_range(0, 5) == 0);
            r_fl  = ($urandom_range(0, 39) == 0);
            for (int k = 0; k < PW / 32; k++)
                r_pay[k*32 +: 32] = $urandom;
            drive(r_rst, r_v, r_pay, r_j, r_e, r_rdy, r_res, r_fl);
            #1;
            e_ld = !r_rst && (mq.size() < 2) && (ms == 2'b00);
            chk("rnd_ld",    c, PW'(ld_d2), PW'(e_ld));
            chk("rnd_agv",   c, PW'(ag_v),  PW'(mq.size() != 0));
            chk("rnd_occ",   c, PW'(occ),   PW'(mq.size()));
            chk("rnd_state", c, PW'(st),    PW'(ms));
            if (mq.size() != 0)
                chk("rnd_pay", c, ag_pay, mq[0]);

            if (r_rst || r_fl) begin
                mq.delete();
                ms = 2'b00;
            end else begin
                acc = r_v && e_ld;
                pp  = (mq.size() != 0) && r_rdy;
                if (pp)
                    void'(mq.pop_front());
                if (acc)
                    mq.push_back(r_pay);
                if (ms == 2'b00 && acc && r_e)
                    ms = 2'b10;
                else if (ms == 2'b00 && acc && r_j)
                    ms = 2'b01;
                else if (ms == 2'b01 && r_res)
                    ms = 2'b00;
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
